// File: rtl/decode_pkg.sv
// Shared types, RV64I opcode constants and immediate generation for decode_stage.
package decode_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;

  typedef enum logic [3:0] {
    OP_NONE    = 4'd0,
    OP_LUI     = 4'd1,
    OP_AUIPC   = 4'd2,
    OP_JAL     = 4'd3,
    OP_JALR    = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_LOAD    = 4'd6,
    OP_STORE   = 4'd7,
    OP_OPIMM   = 4'd8,
    OP_OPIMM32 = 4'd9,
    OP_OP      = 4'd10,
    OP_OP32    = 4'd11,
    OP_SYSTEM  = 4'd12,
    OP_FENCE   = 4'd13,
    OP_ILLEGAL = 4'd14
  } op_class_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    op_class_e       op_class;
    logic            illegal;
  } decoded_t;

  function automatic op_class_e op_class_of(input logic [6:0] opc);
    op_class_e cls;
    unique case (opc)
      OPC_LUI:     cls = OP_LUI;
      OPC_AUIPC:   cls = OP_AUIPC;
      OPC_JAL:     cls = OP_JAL;
      OPC_JALR:    cls = OP_JALR;
      OPC_BRANCH:  cls = OP_BRANCH;
      OPC_LOAD:    cls = OP_LOAD;
      OPC_STORE:   cls = OP_STORE;
      OPC_OPIMM:   cls = OP_OPIMM;
      OPC_OPIMM32: cls = OP_OPIMM32;
      OPC_OP:      cls = OP_OP;
      OPC_OP32:    cls = OP_OP32;
      OPC_SYSTEM:  cls = OP_SYSTEM;
      OPC_FENCE:   cls = OP_FENCE;
      default:     cls = OP_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] instr, input op_class_e cls);
    logic [XLEN-1:0] imm;
    unique case (cls)
      OP_JALR, OP_LOAD, OP_OPIMM, OP_OPIMM32, OP_SYSTEM, OP_FENCE:
        imm = {{52{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {{32{instr[31]}}, instr[31:12], 12'h000};
      OP_JAL:
        imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry valid/ready skid buffer with flush; the ready output is registered.
module decode_skid_buffer
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             ready_q;
  logic             accept;
  logic             consume;

  assign accept      = in_valid_i & ready_q & ~flush_i;
  assign consume     = out_valid_o & out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != BUF_EMPTY);
  assign out_data_o  = head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            head_d  = in_data_i;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && consume) begin
            head_d = in_data_i;
          end else if (accept) begin
            tail_d  = in_data_i;
            state_d = BUF_TWO;
          end else if (consume) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (consume) begin
            head_d  = tail_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // ready is the registered image of "next state is not full"
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (state_d != BUF_TWO);
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: skid-buffered fetch words decoded into fields, immediate and op class.
// Optional DECODE_STATS_EN adds saturating consume and stall counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = 64,
  parameter int unsigned REGISTER_WIDTH    = 64,
  parameter int unsigned INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits,
  input  logic [ADDRESS_WIDTH-1:0]     in_pcplus1,
  input  logic                         in_ready,
  output logic                         out_fetch_enable,
  input  logic                         in_flush,
  input  logic                         in_exec_ready,
  output logic                         out_valid,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [ADDRESS_WIDTH-1:0]     out_pcplus1,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [2:0]                   out_funct3,
  output logic [6:0]                   out_funct7,
  output logic [REGISTER_WIDTH-1:0]    out_imm,
  output logic [3:0]                   out_op_class,
  output logic                         out_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]                  out_stat_decoded,
  output logic [31:0]                  out_stat_stall
`endif
);

  localparam int unsigned ENTRY_W = INSTRUCTION_WIDTH + ADDRESS_WIDTH;

  logic [ENTRY_W-1:0]           head;
  logic [INSTRUCTION_WIDTH-1:0] head_instr;
  logic [ADDRESS_WIDTH-1:0]     head_pcp1;
  logic [31:0]                  instr;
  logic                         buf_valid;
  logic                         seen_q, seen_d;
  logic                         show;
  decoded_t                     dec;
  op_class_e                    cls;
  logic                         illegal;

  decode_skid_buffer #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk_i      (clk),
    .rst_i      (reset),
    .in_data_i  ({in_instruction_bits, in_pcplus1}),
    .in_valid_i (in_ready),
    .in_ready_o (out_fetch_enable),
    .flush_i    (in_flush),
    .out_data_o (head),
    .out_valid_o(buf_valid),
    .out_ready_i(in_exec_ready)
  );

  assign {head_instr, head_pcp1} = head;
  assign instr     = head_instr[31:0];
  assign out_valid = buf_valid;

  // Until the first word arrives the outputs must read as zero/OP_NONE;
  // afterwards the stale head keeps decoding, which holds the last value.
  assign seen_d = seen_q | buf_valid;
  assign show   = buf_valid | seen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
    end
  end

  always_comb begin
    cls     = op_class_of(instr[6:0]);
    illegal = (instr[1:0] != 2'b11) || (cls == OP_ILLEGAL) || (instr == '0);
    dec          = '0;
    dec.op_class = OP_NONE;
    if (show) begin
      dec.rs1      = instr[19:15];
      dec.rs2      = instr[24:20];
      dec.rd       = instr[11:7];
      dec.funct3   = instr[14:12];
      dec.funct7   = instr[31:25];
      dec.illegal  = illegal;
      dec.op_class = illegal ? OP_ILLEGAL : cls;
      dec.imm      = illegal ? '0 : imm_gen(instr, cls);
    end
  end

  assign out_rs1      = dec.rs1;
  assign out_rs2      = dec.rs2;
  assign out_rd       = dec.rd;
  assign out_funct3   = dec.funct3;
  assign out_funct7   = dec.funct7;
  assign out_imm      = REGISTER_WIDTH'(dec.imm);
  assign out_op_class = dec.op_class;
  assign out_illegal  = dec.illegal;
  assign out_pcplus1  = show ? head_pcp1 : '0;
  assign out_pc       = show ? (head_pcp1 - ADDRESS_WIDTH'(4)) : '0;

`ifdef DECODE_STATS_EN
  logic [31:0] stat_dec_q, stat_dec_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_dec_d   = stat_dec_q;
    stat_stall_d = stat_stall_q;
    if (buf_valid && in_exec_ready && (stat_dec_q != '1)) begin
      stat_dec_d = stat_dec_q + 32'd1;
    end
    if (in_ready && !out_fetch_enable && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_dec_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_dec_q   <= stat_dec_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign out_stat_decoded = stat_dec_q;
  assign out_stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-level model plus literal spot checks.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_instruction_bits = '0;
  logic [63:0] in_pcplus1 = '0;
  logic        in_ready = 1'b0;
  logic        in_flush = 1'b0;
  logic        in_exec_ready = 1'b0;
  logic        out_fetch_enable, out_valid, out_illegal;
  logic [63:0] out_pc, out_pcplus1, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [3:0]  out_op_class;
`ifdef DECODE_STATS_EN
  logic [31:0] out_stat_decoded, out_stat_stall;
`endif

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  decode_stage #(
    .ADDRESS_WIDTH(64),
    .REGISTER_WIDTH(64),
    .INSTRUCTION_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_instruction_bits(in_instruction_bits),
    .in_pcplus1(in_pcplus1),
    .in_ready(in_ready),
    .out_fetch_enable(out_fetch_enable),
    .in_flush(in_flush),
    .in_exec_ready(in_exec_ready),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_pcplus1(out_pcplus1),
    .out_rs1(out_rs1),
    .out_rs2(out_rs2),
    .out_rd(out_rd),
    .out_funct3(out_funct3),
    .out_funct7(out_funct7),
    .out_imm(out_imm),
    .out_op_class(out_op_class),
    .out_illegal(out_illegal)
`ifdef DECODE_STATS_EN
    ,
    .out_stat_decoded(out_stat_decoded),
    .out_stat_stall(out_stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode written from the ISA encoding tables.
  function automatic void model_dec(input logic [31:0] w, output logic [3:0] cls,
                                    output logic [63:0] imm, output logic ill);
    byte fmt;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    longint v;
    fmt = "R";
    case (w[6:0])
      7'h37: begin cls = OP_LUI;     fmt = "U"; end
      7'h17: begin cls = OP_AUIPC;   fmt = "U"; end
      7'h6F: begin cls = OP_JAL;     fmt = "J"; end
      7'h67: begin cls = OP_JALR;    fmt = "I"; end
      7'h63: begin cls = OP_BRANCH;  fmt = "B"; end
      7'h03: begin cls = OP_LOAD;    fmt = "I"; end
      7'h23: begin cls = OP_STORE;   fmt = "S"; end
      7'h13: begin cls = OP_OPIMM;   fmt = "I"; end
      7'h1B: begin cls = OP_OPIMM32; fmt = "I"; end
      7'h33: begin cls = OP_OP;      fmt = "R"; end
      7'h3B: begin cls = OP_OP32;    fmt = "R"; end
      7'h73: begin cls = OP_SYSTEM;  fmt = "I"; end
      7'h0F: begin cls = OP_FENCE;   fmt = "I"; end
      default: cls = OP_ILLEGAL;
    endcase
    ill = (cls == OP_ILLEGAL) || (w[1:0] != 2'b11) || (w == 32'h0);
    v = 0;
    case (fmt)
      "I": begin i12 = w[31:20]; v = i12; end
      "S": begin i12 = {w[31:25], w[11:7]}; v = i12; end
      "B": begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = b13; end
      "U": begin u32 = {w[31:12], 12'h000}; v = u32; end
      "J": begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = j21; end
      default: v = 0;
    endcase
    if (ill) begin
      cls = OP_ILLEGAL;
      v = 0;
    end
    imm = v;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc1;
  } ent_t;

  ent_t mq[$];
  bit   m_fen = 1'b1;
  int   m_dec = 0;
  int   m_stall = 0;

  always @(posedge clk or posedge reset) begin
    bit   acc, con;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_fen = 1'b1;
      m_dec = 0;
      m_stall = 0;
    end else begin
      acc = in_ready && m_fen && !in_flush;
      con = (mq.size() > 0) && in_exec_ready;
      if (con) m_dec++;
      if (in_ready && !m_fen) m_stall++;
      if (con) e = mq.pop_front();
      if (in_flush) mq.delete();
      else if (acc) begin
        e.instr = in_instruction_bits;
        e.pc1 = in_pcplus1;
        mq.push_back(e);
      end
      m_fen = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    logic [3:0]  ecls;
    logic [63:0] eimm;
    logic        eill;
    logic [31:0] w;
    if (started) begin
      chk("valid", out_valid, 64'(mq.size() > 0));
      chk("fetch_enable", out_fetch_enable, 64'(m_fen));
`ifdef DECODE_STATS_EN
      chk("stat_decoded", out_stat_decoded, 64'(m_dec));
      chk("stat_stall", out_stat_stall, 64'(m_stall));
`endif
      if (mq.size() > 0) begin
        w = mq[0].instr;
        model_dec(w, ecls, eimm, eill);
        chk("rs1", out_rs1, 64'(w[19:15]));
        chk("rs2", out_rs2, 64'(w[24:20]));
        chk("rd", out_rd, 64'(w[11:7]));
        chk("funct3", out_funct3, 64'(w[14:12]));
        chk("funct7", out_funct7, 64'(w[31:25]));
        chk("imm", out_imm, eimm);
        chk("op_class", out_op_class, 64'(ecls));
        chk("illegal", out_illegal, 64'(eill));
        chk("pcplus1", out_pcplus1, mq[0].pc1);
        chk("pc", out_pc, mq[0].pc1 - 64'd4);
      end
    end
  end

  task automatic drive(input logic rdy, input logic [31:0] w, input logic [63:0] p,
                       input logic ex, input logic fl);
    in_ready = rdy;
    in_instruction_bits = w;
    in_pcplus1 = p;
    in_exec_ready = ex;
    in_flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
  endtask

  logic [31:0] tbl [8];

  initial begin
    tbl[0] = 32'hFFF00093;  // addi x1,x0,-1
    tbl[1] = 32'hFE000EE3;  // beq -4
    tbl[2] = 32'h0080006F;  // jal +8
    tbl[3] = 32'h800000B7;  // lui
    tbl[4] = 32'h00112623;  // sw x1,12(x2)
    tbl[5] = 32'h002081B3;  // add x3,x1,x2
    tbl[6] = 32'h00000000;
    tbl[7] = 32'h00000001;

    @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_fetch_enable", out_fetch_enable, 64'd1);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_class", out_op_class, 64'(OP_NONE));
    chk("rst_illegal", out_illegal, 64'd0);
    started = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    drive(1'b1, 32'hFFF00093, 64'h1004, 1'b1, 1'b0);
    chk("addi_rd", out_rd, 64'd1);
    chk("addi_rs1", out_rs1, 64'd0);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_class", out_op_class, 64'(OP_OPIMM));
    chk("addi_pc", out_pc, 64'h1000);
    chk("stream_fen", out_fetch_enable, 64'd1);
    drive(1'b1, 32'hFE000EE3, 64'h1008, 1'b1, 1'b0);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 32'h0080006F, 64'h100C, 1'b1, 1'b0);
    chk("jal_imm", out_imm, 64'd8);
    drive(1'b1, 32'h800000B7, 64'h1010, 1'b1, 1'b0);
    chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    drive(1'b1, 32'h00112623, 64'h1014, 1'b1, 1'b0);
    chk("sw_imm", out_imm, 64'd12);
    chk("sw_class", out_op_class, 64'(OP_STORE));
    drive(1'b1, 32'h002081B3, 64'h1018, 1'b1, 1'b0);
    chk("add_imm", out_imm, 64'd0);
    chk("add_rs2", out_rs2, 64'd2);
    drive(1'b1, 32'h00000000, 64'h0, 1'b1, 1'b0);
    chk("zero_illegal", out_illegal, 64'd1);
    chk("zero_class", out_op_class, 64'(OP_ILLEGAL));
    chk("zero_pc_wrap", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    idle();
    chk("drain_valid", out_valid, 64'd0);

    // back-pressure: three cycles of exec stall with fetch presenting words
    drive(1'b1, 32'h00100293, 64'h2004, 1'b0, 1'b0);
    drive(1'b1, 32'h00200313, 64'h2008, 1'b0, 1'b0);
    chk("stall_fen", out_fetch_enable, 64'd0);
    chk("stall_head", out_rd, 64'd5);
    drive(1'b1, 32'h00300393, 64'h200C, 1'b0, 1'b0);
    chk("stall_head2", out_rd, 64'd5);
    drive(1'b1, 32'h00300393, 64'h200C, 1'b1, 1'b0);
    chk("release_head", out_rd, 64'd6);
    drive(1'b1, 32'h00300393, 64'h200C, 1'b1, 1'b0);
    chk("release_head2", out_rd, 64'd7);
    idle();

    // flush while full with a fetch word present
    drive(1'b1, 32'h00100293, 64'h3004, 1'b0, 1'b0);
    drive(1'b1, 32'h00200313, 64'h3008, 1'b0, 1'b0);
    drive(1'b1, 32'h00300393, 64'h300C, 1'b0, 1'b1);
    chk("flush_valid", out_valid, 64'd0);
    chk("flush_fen", out_fetch_enable, 64'd1);
    idle();
    chk("flush_dropped", out_valid, 64'd0);

    for (int i = 0; i < 48; i++) begin
      drive(1'b1 & ((i % 3) != 2), tbl[i % 8], 64'h8000 + 64'(4 * i),
            ((i % 4) != 1) && ((i % 7) != 3), (i == 20) || (i == 33));
    end

    // async reset mid-cycle while full
    drive(1'b1, 32'h00100293, 64'h4004, 1'b0, 1'b0);
    drive(1'b1, 32'h00200313, 64'h4008, 1'b0, 1'b0);
    in_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 64'd0);
    chk("async_rst_fen", out_fetch_enable, 64'd1);
`ifdef DECODE_STATS_EN
    chk("async_rst_stat_dec", out_stat_decoded, 64'd0);
    chk("async_rst_stat_stall", out_stat_stall, 64'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 32'h00112623, 64'h5004, 1'b1, 1'b0);
    chk("post_rst_sw", out_imm, 64'd12);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Accepts 32-bit RV64I instruction words with their pc+4, and holds them in a 2-entry skid buffer.
- Decodes the head entry into register indices, a sign-extended immediate, an op class and an illegal flag for the execute stage.
- Provides the enable back-pressure into fetch and flushes on a taken branch.

Parameters:
- ADDRESS_WIDTH, 64, width of pc values.
- REGISTER_WIDTH, 64, width of the immediate output.
- INSTRUCTION_WIDTH, 32, width of the instruction word.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_instruction_bits  in  INSTRUCTION_WIDTH  instruction word from fetch.
- in_pcplus1  in  ADDRESS_WIDTH  pc+4 of that instruction.
- in_ready  in  1  fetch word valid this cycle.
- out_fetch_enable  out  1  decode can accept a word (drives fetch in_enable).
- in_flush  in  1  taken branch; discard all held words.
- in_exec_ready  in  1  execute consumes the head this cycle.
- out_valid  out  1  head entry valid.
- out_pc  out  ADDRESS_WIDTH  pc of head (in_pcplus1 - 4).
- out_pcplus1  out  ADDRESS_WIDTH  pc+4 of head.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_funct3  out  3  funct3 field.
- out_funct7  out  7  funct7 field.
- out_imm  out  REGISTER_WIDTH  sign-extended immediate.
- out_op_class  out  4  op_class_e value.
- out_illegal  out  1  head is not a legal RV64I encoding.

Behaviour:
- Reset (async, immediate):
  - Buffer EMPTY.
  - out_valid=0, out_fetch_enable=1.
  - All data outputs 0; out_op_class=OP_NONE.
- Buffer states:
  - EMPTY: 0 entries.
  - ONE: 1 entry.
  - TWO: 2 entries (skid).
- Handshakes:
  - out_fetch_enable = (state!=TWO), registered.
  - accept = in_ready & out_fetch_enable & ~in_flush.
  - consume = out_valid & in_exec_ready.
- State transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & ~consume -> TWO; consume & ~accept -> EMPTY; accept & consume -> ONE, new word becomes head; otherwise hold.
  - TWO: consume -> ONE, tail shifts to head. Accept is impossible in TWO.
- in_flush:
  - Next edge -> EMPTY, regardless of accept or consume.
  - A flush-cycle fetch word is dropped.
  - The head may still be consumed in the flush cycle.
- Decode is combinational from the head register, so latency is one cycle from accept to out_valid.
- Outputs:
  - out_pc = out_pcplus1 - 4, modulo 2^ADDRESS_WIDTH.
  - When out_valid=0, data outputs hold their last value but are don't-care.
- Immediates (sign bit = instr[31], extended to 64 bits):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: imm=0.
- Op classes by opcode:
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPIMM32, OP, OP32, SYSTEM, FENCE.
  - Anything else -> ILLEGAL.
- out_illegal is set when:
  - instr[1:0]!=2'b11, or
  - the opcode is unknown, or
  - instr==0.
- Illegal instructions still flow as valid, with out_op_class=ILLEGAL and imm=0.
- Reset mid-operation drops all entries immediately.

Optional Feature:
- Macro DECODE_STATS_EN.
- Defined:
  - Adds outputs out_stat_decoded[31:0] (increments on each consume) and out_stat_stall[31:0] (increments each cycle in_ready=1 & out_fetch_enable=0).
  - Both reset to 0, saturate at all-ones, and are cleared by reset only.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package decode_pkg:
  - typedef enum op_class_e (4-bit), including OP_NONE and OP_ILLEGAL.
  - RV64I opcode localparams.
  - typedef struct decoded_t for the output bundle.
  - Function imm_gen(instr, op_class).
- One sub-module: decode_skid_buffer, generic 2-entry valid/ready buffer of {instr, pcplus1}.
- Field extraction and imm generation stay in decode_stage.

Test Plan:
- Stream of words, in_exec_ready=1 always -> each appears one cycle after accept; out_fetch_enable stays 1.
  - Example: ADDI x1,x0,-1 (0xFFF00093) -> rs1=0, rd=1, imm=0xFFFF_FFFF_FFFF_FFFF, class OPIMM.
- in_exec_ready=0 for 3 cycles with fetch presenting words -> two words buffered, out_fetch_enable=0 the following cycle, no word lost or duplicated; order preserved on release.
- State TWO plus in_flush=1 with in_ready=1 -> next cycle out_valid=0, out_fetch_enable=1; the flush-cycle word is absent from execute.
- Immediate checks:
  - BEQ 0xFE000EE3 -> imm=-4.
  - JAL 0x0080006F -> imm=8.
  - LUI 0x800000B7 -> imm=0xFFFF_FFFF_8000_0000.
  - SW 0x00112623 -> imm=12.
- Illegal/pc checks:
  - 0x00000000 -> out_illegal=1, class ILLEGAL.
  - in_pcplus1=0 -> out_pc=0xFFFF_FFFF_FFFF_FFFC.
- Reset asserted asynchronously mid-cycle while in TWO -> out_valid drops before the next edge; with DECODE_STATS_EN, counters read 0.
